cpu_seq: RTL and testbench

Multi-cycle sequencer for the next-generation NPC core. It replaces single-cycle combinational execution with a registered FETCH/DECODE/EXEC/MEM/WB flow. Instruction and data memory are reached through request/response handshakes, so memories may take variable latency. The block owns the PC and instruction registers, qualifies register-file writes, detects ebreak halt, watchdogs memory stalls and keeps cycle/instret counters for the sim harness.

---
 rtl/cpu_seq_pkg.sv | 26 ++
 rtl/cpu_seq_wdog.sv | 32 +++
 rtl/cpu_seq.sv | 157 +++++++++++++++
 tb/tb_cpu_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding, error codes and reset PC default for the multi-cycle sequencer.
// Contents:
//   seq_state_e    - sequencer states IDLE..ERR
//   ERR_*          - o_err_code values
//   DEF_RESET_PC   - default PC loaded on reset
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } seq_state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_FETCH_TMO = 2'd1;
    localparam logic [1:0] ERR_DATA_TMO  = 2'd2;
    localparam logic [1:0] ERR_MISALIGN  = 2'd3;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/cpu_seq_wdog.sv
// cpu_seq_wdog: wait-state watchdog shared by the FETCH and MEM states.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_clr         - hold counter at zero (asserted outside wait states)
//   i_en          - count one waiting cycle
//   o_expired     - current cycle is the last allowed wait cycle (2^TMO_W-1)
module cpu_seq_wdog #(
    parameter int TMO_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    // Counter holds the number of wait cycles already elapsed, so the
    // (2^TMO_W-1)th wait cycle sees a count of 2^TMO_W-2.
    localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + TMO_W'(1);
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with handshake memories, watchdog and counters.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   o_if_req/o_pc           - fetch request and address (held until i_if_rvalid)
//   i_if_rvalid/i_if_rdata  - fetch response
//   o_ins                   - latched instruction to the decoder
//   i_is_load/i_is_store/i_is_ebreak/i_rdwen - decoder flags, stable DECODE..WB
//   i_next_pc               - next PC from the PC unit
//   o_lsu_req/i_lsu_rvalid  - data request / response
//   o_rf_wen                - register-file write strobe (WB only)
//   o_halt/o_err/o_err_code - terminal status
//   o_cycle/o_instret       - active-cycle and retired-instruction counters
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int              CNT_W    = 64,
    parameter int              TMO_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_if_req,
    output logic [XLEN-1:0]  o_pc,
    input  logic             i_if_rvalid,
    input  logic [31:0]      i_if_rdata,
    output logic [31:0]      o_ins,
    input  logic             i_is_load,
    input  logic             i_is_store,
    input  logic             i_is_ebreak,
    input  logic             i_rdwen,
    input  logic [XLEN-1:0]  i_next_pc,
    output logic             o_lsu_req,
    input  logic             i_lsu_rvalid,
    output logic             o_rf_wen,
    output logic             o_halt,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic [CNT_W-1:0] o_cycle,
    output logic [CNT_W-1:0] o_instret
);

    seq_state_e       r_state;
    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_ins;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;
    logic             r_if_req;
    logic             r_lsu_req;
    logic             r_halt;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic             w_wait;
    logic             w_expired;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM);

    cpu_seq_wdog #(.TMO_W(TMO_W)) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (!w_wait),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    // Request/status outputs are registered alongside the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ins      <= '0;
            r_cycle    <= '0;
            r_instret  <= '0;
            r_if_req   <= 1'b0;
            r_lsu_req  <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (r_state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                r_cycle <= r_cycle + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_FETCH;
                    r_if_req <= 1'b1;
                end
                S_FETCH: begin
                    // A response in the final wait cycle beats the timeout.
                    if (i_if_rvalid) begin
                        r_ins    <= i_if_rdata;
                        r_state  <= S_DECODE;
                        r_if_req <= 1'b0;
                    end else if (w_expired) begin
                        r_state    <= S_ERR;
                        r_if_req   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_FETCH_TMO;
                    end
                end
                S_DECODE: begin
                    if (i_is_ebreak) begin
                        r_state   <= S_HALT;
                        r_halt    <= 1'b1;
                        r_instret <= r_instret + CNT_W'(1);
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (i_is_load || i_is_store) begin
                        r_state   <= S_MEM;
                        r_lsu_req <= 1'b1;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_lsu_rvalid) begin
                        r_state   <= S_WB;
                        r_lsu_req <= 1'b0;
                    end else if (w_expired) begin
                        r_state    <= S_ERR;
                        r_lsu_req  <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_DATA_TMO;
                    end
                end
                S_WB: begin
                    if (i_next_pc[1:0] != 2'b00) begin
                        r_state    <= S_ERR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_MISALIGN;
                    end else begin
                        r_pc      <= i_next_pc;
                        r_instret <= r_instret + CNT_W'(1);
                        r_state   <= S_FETCH;
                        r_if_req  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The write strobe is suppressed when reset lands on the WB cycle.
    assign o_rf_wen   = (r_state == S_WB) && i_rdwen && !i_is_store && !i_rst;
    assign o_if_req   = r_if_req;
    assign o_lsu_req  = r_lsu_req;
    assign o_pc       = r_pc;
    assign o_ins      = r_ins;
    assign o_halt     = r_halt;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_cycle    = r_cycle;
    assign o_instret  = r_instret;

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: randomized transaction-level check of cpu_seq against a per-instruction timing model.
module tb_cpu_seq;

    localparam int          TMO  = 4;
    localparam int          TLIM = (1 << TMO) - 1;
    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam int          K_ALU = 0, K_LD = 1, K_ST = 2, K_EB = 3;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_if_req;
    logic [31:0] o_pc;
    logic        i_if_rvalid = 1'b0;
    logic [31:0] i_if_rdata = '0;
    logic [31:0] o_ins;
    logic        i_is_load = 1'b0, i_is_store = 1'b0, i_is_ebreak = 1'b0, i_rdwen = 1'b0;
    logic [31:0] i_next_pc = '0;
    logic        o_lsu_req;
    logic        i_lsu_rvalid = 1'b0;
    logic        o_rf_wen, o_halt, o_err;
    logic [1:0]  o_err_code;
    logic [63:0] o_cycle, o_instret;

    int          n_vec = 0, n_bad = 0;
    logic [31:0] m_pc;
    logic [63:0] m_instret, m_cycle;

    cpu_seq #(.TMO_W(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst), .o_if_req(o_if_req), .o_pc(o_pc),
        .i_if_rvalid(i_if_rvalid), .i_if_rdata(i_if_rdata), .o_ins(o_ins),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_is_ebreak(i_is_ebreak),
        .i_rdwen(i_rdwen), .i_next_pc(i_next_pc), .o_lsu_req(o_lsu_req),
        .i_lsu_rvalid(i_lsu_rvalid), .o_rf_wen(o_rf_wen), .o_halt(o_halt),
        .o_err(o_err), .o_err_code(o_err_code), .o_cycle(o_cycle), .o_instret(o_instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_dec(input int kind, input logic rdwen, input logic [31:0] npc);
        i_is_load   = (kind == K_LD);
        i_is_store  = (kind == K_ST);
        i_is_ebreak = (kind == K_EB);
        i_rdwen     = rdwen;
        i_next_pc   = npc;
    endtask

    // Leaves the DUT one cycle into FETCH with the model reset.
    task automatic do_reset;
        i_rst = 1'b1; i_if_rvalid = 1'b0; i_lsu_rvalid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("rst_pc", o_pc, RPC);
        chk("rst_ins", o_ins, 0);
        chk("rst_cycle", o_cycle, 0);
        chk("rst_instret", o_instret, 0);
        chk("rst_reqs", {o_if_req, o_lsu_req, o_rf_wen, o_halt, o_err}, 0);
        chk("rst_code", o_err_code, 0);
        @(posedge clk); #1;
        chk("idle_to_fetch", o_if_req, 1);
        chk("idle_no_count", o_cycle, 0);
        m_pc = RPC; m_instret = 0; m_cycle = 0;
    endtask

    // fl/ml: wait cycles before the fetch/data response (>= TLIM means never).
    task automatic run_instr(input int kind, input int fl, input int ml, input logic rdwen,
                             input logic [31:0] npc);
        int n, fw, mw, wen_cnt, wen_at, lsu_cnt, exp_n, exp_lsu, ifq;
        logic pif, done, mem, exp_wen, exp_halt, exp_err;
        logic [1:0] exp_code;
        logic [31:0] ins;
        ins = $urandom;
        i_if_rdata = ins;
        set_dec(kind, rdwen, npc);
        mem = (kind == K_LD) || (kind == K_ST);
        exp_wen = 0; exp_halt = 0; exp_err = 0; exp_code = 0; exp_lsu = 0;
        if (fl >= TLIM) begin
            exp_n = TLIM; exp_err = 1; exp_code = 1;
        end else if (kind == K_EB) begin
            exp_n = fl + 2; exp_halt = 1; m_instret++;
        end else if (mem && ml >= TLIM) begin
            exp_n = fl + 3 + TLIM; exp_err = 1; exp_code = 2; exp_lsu = TLIM;
        end else begin
            exp_n = fl + 4 + (mem ? ml + 1 : 0);
            exp_lsu = mem ? ml + 1 : 0;
            exp_wen = rdwen && (kind != K_ST);
            if (npc[1:0] != 2'b00) begin
                exp_err = 1; exp_code = 3;
            end else begin
                m_pc = npc; m_instret++;
            end
        end
        m_cycle += 64'(exp_n);
        n = 0; fw = 0; mw = 0; wen_cnt = 0; wen_at = 0; lsu_cnt = 0; done = 0;
        while (!done && n < 200) begin
            pif = o_if_req;
            i_if_rvalid = o_if_req && (fw == fl);
            if (o_if_req) fw++;
            i_lsu_rvalid = o_lsu_req && (mw == ml);
            if (o_lsu_req) begin mw++; lsu_cnt++; end
            n++;
            if (o_rf_wen) begin wen_cnt++; wen_at = n; end
            @(posedge clk); #1;
            done = (o_if_req && !pif) || o_halt || o_err;
        end
        i_if_rvalid = 0; i_lsu_rvalid = 0;
        chk("cycles", n, exp_n);
        chk("wen_cnt", wen_cnt, exp_wen ? 1 : 0);
        if (exp_wen) chk("wen_at", wen_at, exp_n);
        chk("lsu_cycles", lsu_cnt, exp_lsu);
        chk("pc", o_pc, m_pc);
        chk("instret", o_instret, m_instret);
        chk("cycle", o_cycle, m_cycle);
        chk("status", {o_halt, o_err, o_err_code}, {exp_halt, exp_err, exp_code});
        if (fl < TLIM) chk("ins", o_ins, ins);
        if (exp_halt) begin
            ifq = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                ifq += o_if_req;
            end
            chk("halt_no_fetch", ifq, 0);
            chk("halt_hold", {o_halt, o_lsu_req, o_rf_wen}, 3'b100);
            chk("halt_cycle", o_cycle, m_cycle);
            chk("halt_instret", o_instret, m_instret);
        end
        if (exp_halt || exp_err) do_reset();
    endtask

    initial begin
        logic [31:0] t;
        int r, fl, ml, k;
        do_reset();
        run_instr(K_ALU, 0, 0, 1, RPC + 4);
        run_instr(K_LD, 0, 2, 1, m_pc + 4);
        run_instr(K_ST, 0, 0, 1, m_pc + 4);
        run_instr(K_ALU, TLIM - 1, 0, 1, m_pc + 4);
        run_instr(K_LD, 1, TLIM - 1, 0, m_pc + 8);
        run_instr(K_ALU, TLIM, 0, 1, m_pc + 4);
        run_instr(K_ALU, 0, 0, 1, 32'h8000_0002);
        run_instr(K_EB, 0, 0, 0, RPC + 4);
        run_instr(K_ST, 0, TLIM, 0, RPC + 4);
        // reset in the middle of MEM, then a stale data response
        set_dec(K_LD, 1, RPC + 4);
        i_if_rvalid = 1;
        @(posedge clk); #1; i_if_rvalid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mem_req", o_lsu_req, 1);
        @(posedge clk); #1;
        i_rst = 1;
        @(posedge clk); #1;
        i_rst = 0;
        chk("abort_lsu", o_lsu_req, 0);
        i_lsu_rvalid = 1;
        @(posedge clk); #1;
        i_lsu_rvalid = 0;
        chk("restart", {o_if_req, o_lsu_req, o_err}, 3'b100);
        chk("restart_pc", o_pc, RPC);
        m_pc = RPC; m_instret = 0; m_cycle = 0;
        run_instr(K_ALU, 0, 0, 1, RPC + 12);
        // reset coinciding with WB must not write or move the PC
        set_dec(K_ALU, 1, RPC + 64);
        i_if_rvalid = 1;
        @(posedge clk); #1; i_if_rvalid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1; #1;
        chk("wb_rst_wen", o_rf_wen, 0);
        @(posedge clk); #1;
        i_rst = 0;
        chk("wb_rst_pc", o_pc, RPC);
        @(posedge clk); #1;
        m_pc = RPC; m_instret = 0; m_cycle = 0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            k = (r == 0) ? K_EB : (r < 6) ? K_LD : (r < 10) ? K_ST : K_ALU;
            fl = ($urandom_range(0, 24) == 0) ? TLIM : $urandom_range(0, 3);
            ml = ($urandom_range(0, 24) == 0) ? TLIM : $urandom_range(0, 3);
            t = $urandom;
            r = $urandom_range(0, 15);
            if (r == 0) t[1:0] = 2'b10;
            else if (r < 8) t = m_pc + 4;
            else t[1:0] = 2'b00;
            run_instr(k, fl, ml, 1'($urandom_range(0, 1)), t);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
